// File: rtl/vga_pkg.sv
// Shared VGA timing types: run-state encoding, per-axis mode constants and
// the helper that turns an axis description into totals and active-window bounds.
package vga_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } run_state_e;

    typedef struct packed {
        int active;
        int fp;
        int sync;
        int bp;
    } axis_timing_t;

    typedef struct packed {
        int total;
        int act_first;
        int act_last;
    } axis_bounds_t;

    localparam axis_timing_t H_640X480_60 = '{active: 640, fp: 16, sync: 96,  bp: 48};
    localparam axis_timing_t V_640X480_60 = '{active: 480, fp: 10, sync: 2,   bp: 33};
    localparam axis_timing_t H_800X600_72 = '{active: 800, fp: 56, sync: 120, bp: 64};
    localparam axis_timing_t V_800X600_72 = '{active: 600, fp: 37, sync: 6,   bp: 23};

    // Axis order is sync, back porch, active, front porch.
    function automatic axis_bounds_t axis_bounds(input int sync, input int bp,
                                                 input int active, input int fp);
        axis_bounds_t b;
        b.total     = sync + bp + active + fp;
        b.act_first = sync + bp;
        b.act_last  = sync + bp + active - 1;
        return b;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter that steps on advance_i and wraps at the
// axis total, plus sync, active-window and visible-coordinate decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int W      = 11
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         advance_i,
    output logic [W-1:0] count_o,
    output logic         wrap_o,
    output logic         sync_o,
    output logic         in_active_o,
    output logic [W-1:0] coord_o
);
    localparam axis_bounds_t BND = axis_bounds(SYNC, BP, ACTIVE, FP);
    localparam logic [W-1:0] LAST      = W'(BND.total - 1);
    localparam logic [W-1:0] ACT_FIRST = W'(BND.act_first);
    localparam logic [W-1:0] ACT_LAST  = W'(BND.act_last);
    localparam logic [W-1:0] SYNC_END  = W'(SYNC);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (advance_i) begin
            count_d = wrap_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign wrap_o      = (count_q == LAST);
    assign sync_o      = (count_q < SYNC_END);
    assign in_active_o = (count_q >= ACT_FIRST) && (count_q <= ACT_LAST);
    assign coord_o     = in_active_o ? (count_q - ACT_FIRST) : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel clock-enable divider, h/v counters with a
// frame-aligned run/stop FSM, and registered sync/blank/coordinate outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_640X480_60.active,
    parameter int H_FP       = H_640X480_60.fp,
    parameter int H_SYNC     = H_640X480_60.sync,
    parameter int H_BP       = H_640X480_60.bp,
    parameter int V_ACTIVE   = V_640X480_60.active,
    parameter int V_FP       = V_640X480_60.fp,
    parameter int V_SYNC     = V_640X480_60.sync,
    parameter int V_BP       = V_640X480_60.bp,
    parameter int CLK_DIV    = 2,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int PIPE_DELAY = 0,
    parameter int COORD_W    = 11
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               enable,
    output logic               pix_ce,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic               active,
    output logic [COORD_W-1:0] sx,
    output logic [COORD_W-1:0] sy,
    output logic               line_start,
    output logic               frame_start,
    output logic               running
);
    localparam axis_bounds_t HBND = axis_bounds(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam axis_bounds_t VBND = axis_bounds(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int DIV_W = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    if (CLK_DIV < 2) begin : g_err_div
        $error("vga_timing_gen: CLK_DIV must be at least 2");
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 7) begin : g_err_dly
        $error("vga_timing_gen: PIPE_DELAY must be in 0..7");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_err_mode
        $error("vga_timing_gen: every timing interval must be at least 1");
    end
    if (HBND.total > (2 ** COORD_W) - 1 || VBND.total > (2 ** COORD_W) - 1) begin : g_err_w
        $error("vga_timing_gen: COORD_W too narrow for the mode totals");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    run_state_e         state_q, state_d;
    logic               counting, advance;
    logic [COORD_W-1:0] h_cnt, v_cnt, h_coord, v_coord;
    logic               h_wrap, v_wrap, h_sync, v_sync, h_act, v_act, act_now;
    logic [2:0]         dec_now, dec_tap;
    logic               vga_clk_q, hs_q, vs_q, blank_n_q, active_q;
    logic               line_start_q, frame_start_q;
    logic [COORD_W-1:0] sx_q, sy_q;

    // Divider free-runs in every state so VGA_CLK never stops.
    assign pix_ce = (div_q == DIV_LAST);
    assign div_d  = pix_ce ? '0 : div_q + 1'b1;

    assign counting = (state_q != ST_IDLE);
    assign advance  = pix_ce && counting;

    vga_axis_counter #(
        .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .W(COORD_W)
    ) u_h (
        .CLK(CLK), .RESET(RESET), .advance_i(advance),
        .count_o(h_cnt), .wrap_o(h_wrap), .sync_o(h_sync),
        .in_active_o(h_act), .coord_o(h_coord)
    );

    vga_axis_counter #(
        .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .W(COORD_W)
    ) u_v (
        .CLK(CLK), .RESET(RESET), .advance_i(advance && h_wrap),
        .count_o(v_cnt), .wrap_o(v_wrap), .sync_o(v_sync),
        .in_active_o(v_act), .coord_o(v_coord)
    );

    // Stopping only completes on the frame wrap, so a frame is never cut short.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (pix_ce && enable) state_d = ST_RUN;
            ST_RUN:      if (!enable) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (advance && h_wrap && v_wrap) begin
                    state_d = ST_IDLE;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    // Internal decode is active-high {hs, vs, act}; all-zero means deasserted.
    assign act_now = counting && h_act && v_act;
    assign dec_now = {counting && h_sync, counting && v_sync, act_now};

    if (PIPE_DELAY == 0) begin : g_nodly
        assign dec_tap = dec_now;
    end else begin : g_dly
        logic [2:0] dly_q [PIPE_DELAY];
        always_ff @(posedge CLK) begin
            if (RESET) begin
                for (int i = 0; i < PIPE_DELAY; i++) dly_q[i] <= '0;
            end else if (pix_ce) begin
                dly_q[0] <= dec_now;
                for (int i = 1; i < PIPE_DELAY; i++) dly_q[i] <= dly_q[i-1];
            end
        end
        assign dec_tap = dly_q[PIPE_DELAY-1];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vga_clk_q     <= 1'b0;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            blank_n_q     <= 1'b0;
            active_q      <= 1'b0;
            sx_q          <= '0;
            sy_q          <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            vga_clk_q     <= (div_d >= DIV_HALF);
            hs_q          <= dec_tap[2] ? HS_POL : ~HS_POL;
            vs_q          <= dec_tap[1] ? VS_POL : ~VS_POL;
            blank_n_q     <= dec_tap[0];
            active_q      <= dec_tap[0];
            sx_q          <= act_now ? h_coord : '0;
            sy_q          <= act_now ? v_coord : '0;
            line_start_q  <= counting && (h_cnt == '0);
            frame_start_q <= counting && (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign VGA_CLK     = vga_clk_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_n_q;
    assign VGA_SYNC_N  = 1'b1;
    assign active      = active_q;
    assign sx          = sx_q;
    assign sy          = sy_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign running     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster so whole frames,
// stop/restart and mid-frame reset fit in a short run.
module tb_vga_timing_gen;
    localparam int HA = 8, HF = 2, HS = 3, HB = 2;
    localparam int VA = 5, VF = 1, VS = 2, VB = 2;
    localparam int DIV = 3, PD = 3, CW = 6;
    localparam bit HPOL = 1'b1, VPOL = 1'b0;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FRAME = HT * VT;
    localparam int NPH = 10;

    logic CLK = 1'b0, RESET = 1'b1, enable = 1'b0;
    logic pix_ce, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N;
    logic active, line_start, frame_start, running;
    logic [CW-1:0] sx, sy;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV), .HS_POL(HPOL), .VS_POL(VPOL),
        .PIPE_DELAY(PD), .COORD_W(CW)
    ) dut (
        .CLK(CLK), .RESET(RESET), .enable(enable), .pix_ce(pix_ce),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .VGA_BLANK_N(VGA_BLANK_N), .VGA_SYNC_N(VGA_SYNC_N), .active(active),
        .sx(sx), .sy(sy), .line_start(line_start), .frame_start(frame_start),
        .running(running)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic hs, vs, bn, act;
        logic [CW-1:0] sx, sy;
        logic ls, fs, run, vclk, syn;
    } obs_t;

    obs_t sb[$];
    logic [2:0] hist[$];
    bit m_run;
    int m_p;
    int vectors = 0, errors = 0, gap = -1;
    bit armed = 1'b0;
    obs_t mon_got, mon_exp;

    int ph_len [NPH] = '{400, 220, 60, 40, 120, 600, 70, 0, 150, 500};
    int ph_mode[NPH] = '{0,   1,   0,  1,  0,   2,   0,  3, 0,   2};

    function automatic obs_t sample_dut();
        return {VGA_HS, VGA_VS, VGA_BLANK_N, active, sx, sy,
                line_start, frame_start, running, VGA_CLK, VGA_SYNC_N};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("hs=%b vs=%b bn=%b act=%b sx=%0d sy=%0d ls=%b fs=%b run=%b clk=%b syn=%b",
                         o.hs, o.vs, o.bn, o.act, o.sx, o.sy, o.ls, o.fs, o.run, o.vclk, o.syn);
    endfunction

    // Reference: pixel p of a frame sits at column p%HT, line p/HT; sync/blank
    // are seen PD pixel periods late, coordinates and strobes immediately.
    task automatic push_expect();
        int h, v;
        bit hs_r, vs_r, act_r;
        logic [2:0] d;
        obs_t e;
        h = m_p % HT;
        v = m_p / HT;
        hs_r  = m_run && (h < HS);
        vs_r  = m_run && (v < VS);
        act_r = m_run && (h >= HS + HB) && (h < HS + HB + HA) &&
                (v >= VS + VB) && (v < VS + VB + VA);
        hist.push_back({hs_r, vs_r, act_r});
        d = hist.pop_front();
        e.hs   = d[2] ? HPOL : ~HPOL;
        e.vs   = d[1] ? VPOL : ~VPOL;
        e.bn   = d[0];
        e.act  = d[0];
        e.sx   = act_r ? CW'(h - (HS + HB)) : '0;
        e.sy   = act_r ? CW'(v - (VS + VB)) : '0;
        e.ls   = m_run && (h == 0);
        e.fs   = m_run && (m_p == 0);
        e.run  = m_run;
        e.vclk = ((DIV - 1) >= (DIV / 2));
        e.syn  = 1'b1;
        sb.push_back(e);
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_p = 0;
        hist.delete();
        for (int i = 0; i < PD; i++) hist.push_back(3'b000);
        sb.delete();
        push_expect();
    endtask

    // Start only when idle, stop only at the end of the last pixel of a frame.
    task automatic model_step(input bit en);
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_p = 0;
            end
        end else if (m_p == FRAME - 1) begin
            m_p = 0;
            if (!en) m_run = 1'b0;
        end else begin
            m_p++;
        end
    endtask

    task automatic check_idle(input string name);
        obs_t got, want;
        got = sample_dut();
        want = '0;
        want.hs = ~HPOL;
        want.vs = ~VPOL;
        want.syn = 1'b1;
        vectors++;
        if (got !== want || pix_ce !== 1'b0) begin
            errors++;
            $display("FAIL %s: got %s pix_ce=%b, want %s pix_ce=0", name, fmt(got), pix_ce, fmt(want));
        end
    endtask

    task automatic wait_pix();
        int k;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!pix_ce && k < 4 * DIV);
        if (!pix_ce) begin
            vectors++;
            errors++;
            $display("FAIL pix_ce_timeout: got no pix_ce in %0d clocks, want one every %0d", k, DIV);
        end
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1 RESET = 1'b1;
        @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_idle("post_reset_idle");
        model_reset();
    endtask

    // Monitor: every pix_ce cycle presents one pixel; between pulses VGA_CLK follows the divider phase.
    always @(negedge CLK) begin
        if (RESET) begin
            gap = -1;
        end else if (armed) begin
            if (gap >= 0) gap++;
            if (pix_ce) begin
                if (gap > 0) begin
                    vectors++;
                    if (gap != DIV) begin
                        errors++;
                        $display("FAIL pix_ce_period: got %0d clocks, want %0d", gap, DIV);
                    end
                end
                gap = 0;
                mon_got = sample_dut();
                vectors++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_empty: got %s, want no output", fmt(mon_got));
                end else begin
                    mon_exp = sb.pop_front();
                    if (mon_got !== mon_exp) begin
                        errors++;
                        $display("FAIL pixel_outputs: got %s, want %s", fmt(mon_got), fmt(mon_exp));
                    end
                end
            end else if (gap > 0) begin
                vectors++;
                if (VGA_CLK !== ((gap - 1) >= (DIV / 2))) begin
                    errors++;
                    $display("FAIL vga_clk_phase: got %b at phase %0d, want %b",
                             VGA_CLK, gap - 1, ((gap - 1) >= (DIV / 2)));
                end
            end
        end
    end

    initial begin
        RESET = 1'b1;
        enable = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RESET = 1'b0;
        @(negedge CLK);
        check_idle("reset_idle");
        model_reset();
        armed = 1'b1;
        for (int ph = 0; ph < NPH; ph++) begin
            if (ph_mode[ph] == 3) begin
                do_reset();
            end else begin
                for (int n = 0; n < ph_len[ph]; n++) begin
                    wait_pix();
                    model_step(enable);
                    push_expect();
                    @(negedge CLK);
                    case (ph_mode[ph])
                        0: enable = 1'b1;
                        1: enable = 1'b0;
                        default: if ($urandom_range(0, 24) == 0) enable = ~enable;
                    endcase
                end
            end
        end
        @(negedge CLK);
        armed = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no end of stimulus, want completion before time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. Runs from the 50 MHz system clock and derives a pixel clock-enable and an output pixel clock, so no logic is clocked by a derived clock. Produces sync, blank, active-area flag, pixel coordinates and line/frame strobes for the pixel pipeline and DAC. Supports any mode via parameters, sync polarity, pipeline-delay alignment and frame-aligned start/stop.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, CLK cycles per pixel (>=2)
HS_POL, 0, asserted level of VGA_HS
VS_POL, 0, asserted level of VGA_VS
PIPE_DELAY, 0, extra pixel periods of delay on HS/VS/BLANK_N/active (0..7)
COORD_W, 11, width of sx/sy

Ports:
CLK  in  1  system clock, 50 MHz
RESET  in  1  synchronous, active-high
enable  in  1  run request; start/stop take effect only at frame boundary
pix_ce  out  1  one-CLK pulse per pixel period
VGA_CLK  out  1  pixel clock to DAC, registered, CLK/CLK_DIV
VGA_HS  out  1  horizontal sync, polarity HS_POL
VGA_VS  out  1  vertical sync, polarity VS_POL
VGA_BLANK_N  out  1  low outside active area
VGA_SYNC_N  out  1  constant 1
active  out  1  high inside visible area
sx  out  COORD_W  visible column, 0 outside active
sy  out  COORD_W  visible line, 0 outside active
line_start  out  1  one pix_ce-wide pulse at h_cnt==0
frame_start  out  1  one pix_ce-wide pulse at h_cnt==0 and v_cnt==0
running  out  1  high while state is RUN or STOPPING

Behaviour:
- H_TOTAL=H_SYNC+H_BP+H_ACTIVE+H_FP (800); V_TOTAL likewise (525). Line order is sync, back porch, active, front porch. Vertical order is the same.
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pix_ce=1 in the cycle where div_cnt==CLK_DIV-1. VGA_CLK is registered, =1 when div_cnt>=CLK_DIV/2. The divider runs in all states.
- Counters: h_cnt and v_cnt advance only on CLK edges where pix_ce=1 and state is RUN or STOPPING.
  - h_cnt wraps from H_TOTAL-1 to 0 and increments v_cnt.
  - v_cnt wraps from V_TOTAL-1 to 0.
- Decode from counters:
  - hs = h_cnt<H_SYNC; vs = v_cnt<V_SYNC.
  - act = h_cnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and v_cnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1].
  - sx = h_cnt-(H_SYNC+H_BP) when act, else 0; sy likewise.
- Registering: all outputs are registered, 1 CLK after the counter update.
  - HS/VS/BLANK_N/active pass through an additional PIPE_DELAY-stage shift register clocked on pix_ce.
  - sx/sy, line_start and frame_start are not delayed.
- FSM:
  - IDLE: counters held at 0; outputs deasserted (HS=!HS_POL, VS=!VS_POL, BLANK_N=0, active=0, sx=sy=0, strobes 0). IDLE -> RUN on pix_ce with enable=1. The first counted pixel is h=0, v=0 and frame_start fires.
  - RUN: enable=0 -> STOPPING.
  - STOPPING: enable=1 -> RUN with no disturbance. On the wrap to h=0, v=0 -> IDLE. A frame is never truncated.
- Reset: counters 0, div_cnt 0, state IDLE, VGA_CLK 0, delay lines cleared to deasserted values, outputs as in IDLE, VGA_SYNC_N 1. Reset mid-frame aborts immediately. Reset has priority over enable.
- Counters are sized for H_TOTAL/V_TOTAL up to 2^COORD_W-1. Out-of-range parameters are an elaboration error.

Decomposition:
- Package vga_pkg holds the mode-timing constants for 640x480@60 and 800x600@72, and a function that computes totals and active-window bounds.
- One sub-module, vga_axis_counter, is instantiated twice (h and v). It has parameters SYNC/BP/ACTIVE/FP and provides count, wrap, sync, in_active and coordinate outputs, with an advance input.

Test Plan:
- Reset, then enable=1 with defaults: pix_ce every 2nd CLK; frame_start at first counted pixel; line_start every 800 pix_ce; frame_start every 420000 pix_ce.
- Horizontal timing check: HS low for pix 0..95; active/BLANK_N high for h 144..783 with sx 0..639; VS low for lines 0..1; sy 0..479 over lines 35..514.
- HS_POL=1, VS_POL=1, PIPE_DELAY=3: sync pulses inverted; HS/active edges lag sx by exactly 3 pix_ce; sx timing unchanged.
- enable dropped at line 100, then held low: output continues to line 524 pixel 799, then IDLE; running falls; no partial frame. Re-raising enable at line 300 while stopping keeps RUN with no glitch.
- RESET pulsed at h=500, v=200: next cycle counters 0, outputs idle, VGA_CLK 0; restart gives a clean frame_start.
- Parameter set 800x600@72 (CLK_DIV=1 rejected; CLK_DIV=2 with H 800/56/120/64, V 600/37/6/23): totals 1040x666, sx max 799, sy max 599.
